axi_light_rr_arbiter: RTL and testbench

//  Shares one AXI4-lite slave (shared memory / interconnect port) between
//  N_MASTERS picorv32 AXI-lite masters. Round-robin grant, one transaction
//  in flight at a time, full AR/R and AW/W/B handshakes routed to the granted

---
 rtl/axi_light_rr_arbiter_if.sv | 73 +++++++
 rtl/axi_light_rr_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_axi_light_rr_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_light_rr_arbiter_if.sv
// Bundles for the round-robin AXI-lite arbiter: a packed per-master request
// bundle (one lane per core) and a single AXI-lite link towards the shared slave.

interface axi_light_rr_arbiter_if #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [N_MASTERS-1:0]          arvalid;
    logic [N_MASTERS-1:0]          arready;
    logic [N_MASTERS*ADDR_W-1:0]   araddr;
    logic [N_MASTERS*3-1:0]        arprot;
    logic [N_MASTERS-1:0]          rvalid;
    logic [N_MASTERS-1:0]          rready;
    logic [DATA_W-1:0]             rdata;
    logic [N_MASTERS-1:0]          awvalid;
    logic [N_MASTERS-1:0]          awready;
    logic [N_MASTERS*ADDR_W-1:0]   awaddr;
    logic [N_MASTERS*3-1:0]        awprot;
    logic [N_MASTERS-1:0]          wvalid;
    logic [N_MASTERS-1:0]          wready;
    logic [N_MASTERS*DATA_W-1:0]   wdata;
    logic [N_MASTERS*DATA_W/8-1:0] wstrb;
    logic [N_MASTERS-1:0]          bvalid;
    logic [N_MASTERS-1:0]          bready;

    modport master (
        output arvalid, araddr, arprot, rready, awvalid, awaddr, awprot,
               wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, awready, wready, bvalid
    );

    modport slave (
        input  arvalid, araddr, arprot, rready, awvalid, awaddr, awprot,
               wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, awready, wready, bvalid
    );
endinterface

interface if_axi_light #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid;
    logic                bready;

    modport master (
        output arvalid, araddr, arprot, rready, awvalid, awaddr, awprot,
               wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, awready, wready, bvalid
    );

    modport slave (
        input  arvalid, araddr, arprot, rready, awvalid, awaddr, awprot,
               wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, awready, wready, bvalid
    );
endinterface

// File: rtl/axi_light_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-lite slave among N_MASTERS cores, one
// transaction in flight. Define ARB_STATS_EN to add per-master grant_count.

module axi_light_rr_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                         clk,
    input  logic                         res,
    axi_light_rr_arbiter_if.slave        s,
    if_axi_light.master                  m,
    output logic [$clog2(N_MASTERS)-1:0] grant_id,
    output logic                         busy
`ifdef ARB_STATS_EN
    ,
    output logic [N_MASTERS*32-1:0]      grant_count
`endif
);

    localparam int GW = $clog2(N_MASTERS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RDATA = 3'd2,
        ST_WR    = 3'd3,
        ST_WRESP = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            busy_q, busy_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [N_MASTERS-1:0] req_s;
    logic [GW-1:0]   pick_s;

    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
        if (g == GW'(N_MASTERS - 1)) begin
            return '0;
        end else begin
            return g + GW'(1);
        end
    endfunction

    assign req_s    = s.arvalid | s.awvalid;
    assign grant_id = grant_q;
    assign busy     = busy_q;

    // Data paths follow the registered grant; only valid/ready are gated by state.
    assign m.araddr = s.araddr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign m.arprot = s.arprot[int'(grant_q)*3 +: 3];
    assign m.awaddr = s.awaddr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign m.awprot = s.awprot[int'(grant_q)*3 +: 3];
    assign m.wdata  = s.wdata[int'(grant_q)*DATA_W +: DATA_W];
    assign m.wstrb  = s.wstrb[int'(grant_q)*(DATA_W/8) +: (DATA_W/8)];
    assign s.rdata  = m.rdata;

    // First requester at or after rr_ptr, scanning cyclically.
    always_comb begin
        int  idx;
        logic found;
        pick_s = rr_ptr_q;
        found  = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_MASTERS) begin
                idx = idx - N_MASTERS;
            end else begin
                idx = idx;
            end
            if (!found && req_s[idx]) begin
                pick_s = GW'(idx);
                found  = 1'b1;
            end else begin
                found  = found;
            end
        end
    end

    // Next-state and handshake routing.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        busy_d    = busy_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        m.arvalid = 1'b0;
        m.rready  = 1'b0;
        m.awvalid = 1'b0;
        m.wvalid  = 1'b0;
        m.bready  = 1'b0;
        s.arready = '0;
        s.rvalid  = '0;
        s.awready = '0;
        s.wready  = '0;
        s.bvalid  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req_s) begin
                    grant_d = pick_s;
                    busy_d  = 1'b1;
                    state_d = s.arvalid[pick_s] ? ST_RD : ST_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                m.arvalid          = 1'b1;
                s.arready[grant_q] = m.arready;
                if (m.arready) begin
                    state_d = ST_RDATA;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_RDATA: begin
                m.rready          = s.rready[grant_q];
                s.rvalid[grant_q] = m.rvalid;
                if (m.rvalid && s.rready[grant_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr(grant_q);
                    busy_d   = 1'b0;
                end else begin
                    state_d  = ST_RDATA;
                end
            end
            ST_WR: begin
                // AW and W complete independently; each channel is masked once done.
                m.awvalid          = s.awvalid[grant_q] & ~aw_done_q;
                m.wvalid           = s.wvalid[grant_q] & ~w_done_q;
                s.awready[grant_q] = m.awready & ~aw_done_q;
                s.wready[grant_q]  = m.wready & ~w_done_q;
                aw_done_d = aw_done_q | (s.awvalid[grant_q] & m.awready);
                w_done_d  = w_done_q | (s.wvalid[grant_q] & m.wready);
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WRESP;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WRESP: begin
                m.bready          = s.bready[grant_q];
                s.bvalid[grant_q] = m.bvalid;
                if (m.bvalid && s.bready[grant_q]) begin
                    state_d   = ST_IDLE;
                    rr_ptr_d  = next_ptr(grant_q);
                    busy_d    = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    state_d   = ST_WRESP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            busy_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= busy_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef ARB_STATS_EN
    logic        txn_done_s;
    logic [31:0] cnt_q [N_MASTERS];

    assign txn_done_s = ((state_q == ST_RDATA) && m.rvalid && s.rready[grant_q]) ||
                        ((state_q == ST_WRESP) && m.bvalid && s.bready[grant_q]);

    // Completed-transaction counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                cnt_q[i] <= 32'd0;
            end
        end else if (txn_done_s) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
        end else begin
            cnt_q[grant_q] <= cnt_q[grant_q];
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            grant_count[i*32 +: 32] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_axi_light_rr_arbiter.sv
// Directed bench for axi_light_rr_arbiter: acts as the four cores and the
// shared slave, comparing against hand-computed expectations.

module tb_axi_light_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic       clk;
    logic       res;
    logic [1:0] grant_id;
    logic       busy;
    int         n_cmp;
    int         n_err;

    axi_light_rr_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) s_if ();
    if_axi_light #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

`ifdef ARB_STATS_EN
    logic [N*32-1:0] grant_count;
`endif

    axi_light_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .res         (res),
        .s           (s_if.slave),
        .m           (m_if.master),
        .grant_id    (grant_id),
        .busy        (busy)
`ifdef ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Slave side of one read for master g: AR handshake, lat idle cycles, then R.
    task automatic slave_read(input int g, input logic [31:0] addr, input logic [31:0] data,
                              input int lat, input bit drop);
        int         n;
        logic [3:0] oh;
        oh = 4'b0001 << g;
        n  = 0;
        #1;
        while (!m_if.arvalid && n < 10) begin
            cyc();
            n++;
        end
        check_val("ar_wait", m_if.arvalid, 1);
        check_val("grant", grant_id, g);
        check_val("araddr", m_if.araddr, addr);
        check_val("arprot", m_if.arprot, g);
        check_val("busy_rd", busy, 1);
        m_if.arready = 1'b1;
        #1;
        check_val("s_arready", s_if.arready, oh);
        cyc();
        m_if.arready = 1'b0;
        if (drop) s_if.arvalid[g] = 1'b0;
        #1;
        check_val("ar_after_hs", m_if.arvalid, 0);
        for (int i = 0; i < lat; i++) begin
            check_val("rvalid_early", s_if.rvalid, 0);
            check_val("m_rready", m_if.rready, 1);
            cyc();
        end
        m_if.rvalid = 1'b1;
        m_if.rdata  = data;
        #1;
        check_val("s_rvalid", s_if.rvalid, oh);
        check_val("s_rdata", s_if.rdata, data);
        cyc();
        m_if.rvalid = 1'b0;
        #1;
    endtask

    task automatic simple_write(input int g);
        s_if.awvalid[g] = 1'b1;
        s_if.wvalid[g]  = 1'b1;
        cyc();
        m_if.awready = 1'b1;
        m_if.wready  = 1'b1;
        cyc();
        m_if.awready    = 1'b0;
        m_if.wready     = 1'b0;
        s_if.awvalid[g] = 1'b0;
        s_if.wvalid[g]  = 1'b0;
        m_if.bvalid     = 1'b1;
        cyc();
        m_if.bvalid = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        res   = 1'b1;
        s_if.arvalid = '0; s_if.awvalid = '0; s_if.wvalid = '0;
        s_if.rready  = 4'hF; s_if.bready = 4'hF;
        for (int i = 0; i < N; i++) begin
            s_if.araddr[i*AW +: AW] = 32'h100 * (i + 1);
            s_if.awaddr[i*AW +: AW] = 32'h1000 * (i + 1);
            s_if.arprot[i*3 +: 3]   = 3'(i);
            s_if.awprot[i*3 +: 3]   = 3'(i);
            s_if.wdata[i*DW +: DW]  = 32'hCAFE0000 + i;
            s_if.wstrb[i*4 +: 4]    = 4'b0110;
        end
        m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0;
        cyc();
        cyc();
        check_val("rst_busy", busy, 0);
        check_val("rst_grant", grant_id, 0);
        check_val("rst_m_valids", {m_if.arvalid, m_if.awvalid, m_if.wvalid}, 0);
        check_val("rst_m_readies", {m_if.rready, m_if.bready}, 0);
        check_val("rst_s_out", {s_if.arready, s_if.awready, s_if.wready, s_if.rvalid, s_if.bvalid}, 0);
        res = 1'b0;
        cyc();

        // T1: single read from M0, data returned three cycles after AR.
        s_if.arvalid[0] = 1'b1;
        #1;
        check_val("t1_no_comb_grant", m_if.arvalid, 0);
        check_val("t1_busy_idle", busy, 0);
        slave_read(0, 32'h100, 32'hDEADBEEF, 3, 1'b1);
        check_val("t1_busy_done", busy, 0);
        check_val("t1_rvalid_gone", s_if.rvalid, 0);
        // rr_ptr must now be 1: between M0 and M2, M2 wins.
        s_if.arvalid[0] = 1'b1;
        s_if.arvalid[2] = 1'b1;
        slave_read(2, 32'h300, 32'h3333, 0, 1'b1);
        slave_read(0, 32'h100, 32'h1111, 0, 1'b1);

        res = 1'b1;
        cyc();
        res = 1'b0;
        cyc();

        // T2: all four reading continuously from rr_ptr=0.
        s_if.arvalid = 4'hF;
        slave_read(0, 32'h100, 32'hA0, 0, 1'b0);
        slave_read(1, 32'h200, 32'hA1, 1, 1'b0);
        slave_read(2, 32'h300, 32'hA2, 0, 1'b0);
        slave_read(3, 32'h400, 32'hA3, 0, 1'b0);
        slave_read(0, 32'h100, 32'hA4, 0, 1'b0);
        s_if.arvalid = '0;
        cyc();

        // T3: M2 write, AW accepted first, W four cycles later.
        s_if.awvalid[2] = 1'b1;
        #1;
        check_val("t3_no_comb_grant", m_if.awvalid, 0);
        cyc();
        check_val("t3_grant", grant_id, 2);
        check_val("t3_awvalid", m_if.awvalid, 1);
        check_val("t3_awaddr", m_if.awaddr, 32'h3000);
        check_val("t3_awprot", m_if.awprot, 2);
        check_val("t3_wvalid_early", m_if.wvalid, 0);
        m_if.awready = 1'b1;
        #1;
        check_val("t3_s_awready", s_if.awready, 4'b0100);
        cyc();
        m_if.awready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("t3_aw_reassert", m_if.awvalid, 0);
            check_val("t3_wvalid_idle", m_if.wvalid, 0);
            check_val("t3_busy", busy, 1);
            cyc();
        end
        s_if.wvalid[2] = 1'b1;
        #1;
        check_val("t3_wvalid", m_if.wvalid, 1);
        check_val("t3_wdata", m_if.wdata, 32'hCAFE0002);
        check_val("t3_wstrb", m_if.wstrb, 4'b0110);
        check_val("t3_aw_reassert_w", m_if.awvalid, 0);
        m_if.wready = 1'b1;
        #1;
        check_val("t3_s_wready", s_if.wready, 4'b0100);
        cyc();
        m_if.wready    = 1'b0;
        s_if.wvalid[2] = 1'b0;
        #1;
        check_val("t3_bready", m_if.bready, 1);
        check_val("t3_aw_in_wresp", m_if.awvalid, 0);
        m_if.bvalid = 1'b1;
        #1;
        check_val("t3_s_bvalid", s_if.bvalid, 4'b0100);
        cyc();
        m_if.bvalid     = 1'b0;
        s_if.awvalid[2] = 1'b0;
        #1;
        check_val("t3_busy_done", busy, 0);
        check_val("t3_bvalid_gone", s_if.bvalid, 0);

        // T4: M3 AW+W accepted together, B stalled by master for five cycles.
        s_if.awvalid[3] = 1'b1;
        s_if.wvalid[3]  = 1'b1;
        s_if.bready[3]  = 1'b0;
        cyc();
        check_val("t4_grant", grant_id, 3);
        check_val("t4_aw_w_valid", {m_if.awvalid, m_if.wvalid}, 2'b11);
        m_if.awready = 1'b1;
        m_if.wready  = 1'b1;
        #1;
        check_val("t4_s_readies", {s_if.awready, s_if.wready}, 8'b1000_1000);
        cyc();
        m_if.awready = 1'b0;
        m_if.wready  = 1'b0;
        s_if.awvalid[3] = 1'b0;
        s_if.wvalid[3]  = 1'b0;
        m_if.bvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("t4_bready_hold", m_if.bready, 0);
            check_val("t4_bvalid_hold", s_if.bvalid, 4'b1000);
            check_val("t4_busy_hold", busy, 1);
            cyc();
        end
        s_if.bready[3] = 1'b1;
        #1;
        check_val("t4_bready", m_if.bready, 1);
        cyc();
        m_if.bvalid = 1'b0;
        #1;
        check_val("t4_busy_done", busy, 0);

        // T5: complete M1 (rr_ptr=2), start M2, reset while in RDATA.
        s_if.arvalid[1] = 1'b1;
        slave_read(1, 32'h200, 32'h5151, 0, 1'b1);
        s_if.arvalid[2] = 1'b1;
        s_if.rready[2]  = 1'b0;
        cyc();
        check_val("t5_grant", grant_id, 2);
        m_if.arready = 1'b1;
        cyc();
        m_if.arready    = 1'b0;
        s_if.arvalid[2] = 1'b0;
        m_if.rvalid     = 1'b1;
        #1;
        check_val("t5_in_rdata", s_if.rvalid, 4'b0100);
        res = 1'b1;
        #1;
        check_val("t5_rst_rvalid", s_if.rvalid, 0);
        check_val("t5_rst_valids", {m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready}, 0);
        check_val("t5_rst_busy", busy, 0);
        check_val("t5_rst_grant", grant_id, 0);
        cyc();
        m_if.rvalid = 1'b0;
        res = 1'b0;
        s_if.rready = 4'hF;
        cyc();
        s_if.arvalid[0] = 1'b1;
        s_if.arvalid[3] = 1'b1;
        slave_read(0, 32'h100, 32'h0F0F, 0, 1'b1);
        slave_read(3, 32'h400, 32'h3F3F, 0, 1'b1);

`ifdef ARB_STATS_EN
        // T6: 10 reads from M1 and 3 writes from M3 after a fresh reset.
        res = 1'b1;
        cyc();
        res = 1'b0;
        cyc();
        check_val("t6_cnt_rst", grant_count, 0);
        for (int i = 0; i < 10; i++) begin
            s_if.arvalid[1] = 1'b1;
            slave_read(1, 32'h200, 32'h600 + i, 0, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            simple_write(3);
        end
        check_val("t6_cnt0", grant_count[31:0], 0);
        check_val("t6_cnt1", grant_count[63:32], 10);
        check_val("t6_cnt2", grant_count[95:64], 0);
        check_val("t6_cnt3", grant_count[127:96], 3);
`else
        simple_write(1);
        check_val("wr_busy_done", busy, 0);
        check_val("wr_grant", grant_id, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
